// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and defaults for the truth-table sequencer: FSM state encoding,
// default parameter values and the run-length helper used by benches.
package tt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int TT_N_IN_DEF   = 2;
    localparam int TT_SETTLE_DEF = 1;
    localparam int TT_CNT_W      = 4;   // wide enough for SETTLE up to 15

    // Clock edges from the start-accepting edge until done rises on a full sweep.
    function automatic int tt_run_cycles(input int n, input int settle);
        return (1 << n) * (settle + 2);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Stimulus/response bundle between the sequencer (slave) and the pair of
// expressions plus whoever requests a run (master).
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic              lhs;
    logic              rhs;
    logic [N_IN-1:0]   vec;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_err_vec;
    logic              first_err_valid;

    modport master (
        output start, lhs, rhs,
        input  vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, lhs, rhs,
        output vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/truth_table_sequencer_tracker.sv
// Mismatch bookkeeping for one sweep: count of failing vectors and the
// first failing vector, cleared when a new run is accepted.
module tt_mismatch_tracker
    import tt_seq_pkg::*;
#(
    parameter int N_IN = TT_N_IN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            sample_en,
    input  logic            mismatch,
    input  logic [N_IN-1:0] vec,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    logic [N_IN:0]   err_count_q;
    logic [N_IN-1:0] first_err_vec_q;
    logic            first_err_valid_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else if (clear) begin
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else if (sample_en && mismatch) begin
            err_count_q <= err_count_q + 1'b1;
            if (!first_err_valid_q) begin
                first_err_vec_q   <= vec;
                first_err_valid_q <= 1'b1;
            end
        end
    end

    assign err_count       = err_count_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps vec through 0..2^N_IN-1, waits SETTLE+1 cycles per vector, then
// compares lhs/rhs. Define TT_STOP_ON_ERR_EN to end the run on the first mismatch.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int N_IN   = TT_N_IN_DEF,
    parameter int SETTLE = TT_SETTLE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sequencer_if.slave  bus
);

    localparam logic [TT_CNT_W-1:0] SETTLE_C = TT_CNT_W'(SETTLE);
    localparam logic [N_IN-1:0]     VEC_LAST = '1;

    tt_state_e             state_q;
    logic [N_IN-1:0]       vec_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [TT_CNT_W-1:0]   cnt_q;

    logic                  clear;
    logic                  sample_en;
    logic                  mismatch;
    logic [N_IN:0]         err_count;
    logic [N_IN-1:0]       first_err_vec;
    logic                  first_err_valid;

    assign clear     = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign sample_en = (state_q == SAMPLE);
    // NOTE: case inequality makes an X/Z on either expression output a mismatch
    // in simulation; synthesis treats it as an ordinary inequality.
    assign mismatch  = (bus.lhs !== bus.rhs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= APPLY;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                APPLY: begin
                    if (cnt_q == SETTLE_C) state_q <= SAMPLE;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                SAMPLE: begin
`ifdef TT_STOP_ON_ERR_EN
                    if (mismatch) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else
`endif
                    if (vec_q == VEC_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // The tracker only counts this vector at the same edge.
                        pass_q  <= (err_count == '0) && !mismatch;
                    end else begin
                        state_q <= APPLY;
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tt_mismatch_tracker #(.N_IN(N_IN)) u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .sample_en       (sample_en),
        .mismatch        (mismatch),
        .vec             (vec_q),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    assign bus.vec             = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_count;
    assign bus.first_err_vec   = first_err_vec;
    assign bus.first_err_valid = first_err_valid;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: each launched run pushes its hand-computed result; a
// monitor pops and compares when done rises, including the vec walk and timing.
module tb_truth_table_sequencer;
    import tt_seq_pkg::*;

    localparam int N_IN   = TT_N_IN_DEF;
    localparam int SETTLE = TT_SETTLE_DEF;
    localparam int FULL   = tt_run_cycles(N_IN, SETTLE);
    localparam int PER    = SETTLE + 2;

    typedef struct {
        int err;
        int fev;
        bit fvalid;
        bit pass;
        int done_cyc;
        int nvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(N_IN)) bus ();

    truth_table_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   mode = 0;
    logic x, y;
    assign x = bus.vec[1];
    assign y = bus.vec[0];

    always_comb begin
        bus.lhs = 1'b0;
        bus.rhs = 1'b0;
        case (mode)
            0: begin bus.lhs = ~x & ~(x | ~y); bus.rhs = ~x & y; end
            1: begin bus.lhs = ~x & y;         bus.rhs = ~x;     end
            2: begin bus.lhs = x | y;          bus.rhs = x ^ y;  end
            default: begin bus.lhs = x;        bus.rhs = y;      end
        endcase
    end

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [N_IN-1:0] trace[$];
    logic done_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: record the vec walk while busy, score each run when done rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            trace.delete();
            done_prev = 1'b0;
        end else begin
            if (bus.busy && (trace.size() == 0 || trace[$] !== bus.vec))
                trace.push_back(bus.vec);
            if (bus.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("err_count", int'(bus.err_count), e.err);
                    check("first_err_vec", int'(bus.first_err_vec), e.fev);
                    check("first_err_valid", int'(bus.first_err_valid), int'(e.fvalid));
                    check("pass", int'(bus.pass), int'(e.pass));
                    check("busy_in_done", int'(bus.busy), 0);
                    check("vec_walk_len", trace.size(), e.nvec);
                    for (int i = 0; i < trace.size() && i < e.nvec; i++)
                        check($sformatf("vec_walk[%0d]", i), int'(trace[i]), i);
                end
                trace.delete();
            end
            done_prev = bus.done;
        end
    end

    // Drive one start pulse accepted at the next edge; returns just after it.
    task automatic launch(input int m, input int err, input int fev, input bit fvalid,
                          input bit pass, input int nvec, input int len);
        exp_t e;
        @(negedge clk);
        mode = m;
        bus.start = 1'b1;
        e.err = err; e.fev = fev; e.fvalid = fvalid; e.pass = pass;
        e.nvec = nvec; e.done_cyc = cyc + 1 + len;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("run_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"}, int'(bus.vec), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_pass"}, int'(bus.pass), 0);
        check({tag, "_err_count"}, int'(bus.err_count), 0);
        check({tag, "_first_err_vec"}, int'(bus.first_err_vec), 0);
        check({tag, "_first_err_valid"}, int'(bus.first_err_valid), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Equivalent pair: full sweep, pass.
        launch(0, 0, 0, 1'b0, 1'b1, 4, FULL);
        check("busy_after_start", int'(bus.busy), 1);
        wait_done();

`ifdef TT_STOP_ON_ERR_EN
        launch(1, 1, 0, 1'b1, 1'b0, 1, 1 * PER);
        wait_done();
        launch(2, 1, 3, 1'b1, 1'b0, 4, FULL);
        wait_done();
        launch(3, 1, 1, 1'b1, 1'b0, 2, 2 * PER);
        wait_done();
        check("stop_vec_frozen", int'(bus.vec), 1);
`else
        launch(1, 1, 0, 1'b1, 1'b0, 4, FULL);
        wait_done();
        launch(2, 1, 3, 1'b1, 1'b0, 4, FULL);
        wait_done();
        launch(3, 2, 1, 1'b1, 1'b0, 4, FULL);
        wait_done();
`endif
        check("done_level_held", int'(bus.done), 1);

        // Restart from DONE clears results; a start pulse mid-run is ignored.
        launch(0, 0, 0, 1'b0, 1'b1, 4, FULL);
        check("restart_done_low", int'(bus.done), 0);
        check("restart_err_cleared", int'(bus.err_count), 0);
        check("restart_fvalid_cleared", int'(bus.first_err_valid), 0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Asynchronous reset mid-run, then a clean restart.
        launch(0, 0, 0, 1'b0, 1'b1, 4, FULL);
        begin
            int budget = 0;
            while (bus.vec !== 2'b01 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            check("reach_vec01", int'(bus.vec), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'(bus.busy), 0);
        launch(0, 0, 0, 1'b0, 1'b1, 4, FULL);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
